mem_uncache_ctrl: RTL
=====================

// Module: mem_uncache_ctrl
// PURPOSE
//  MEM-stage controller for data-memory accesses on the single-outstanding sram-like bus (req/addr_ok/data_ok).
//  Takes one load/store per MEM instruction, drives bus request, byte strobes and replicated write data.
//  Returns raw load word as MEM_DMOut; sign/zero extension is done in WB.
//  Stalls the pipeline until the access completes, then holds the result until the MEM/WB register captures it.
// PARAMETERS
//  TIMEOUT_CYCLES  255  max cycles in WAIT before bus error is declared; 0 disables the watchdog
// PORTS
//  clk            in   1   clock
//  rst            in   1   reset, asynchronous, active-high
//  MEM_Req        in   1   MEM instruction performs a data access
//  MEM_IsStore    in   1   1 = store, 0 = load
//  MEM_Size       in   2   0 byte, 1 half, 2 word (3 is treated as word)
//  MEM_Addr       in   32  byte address; alignment already checked upstream
//  MEM_WData      in   32  store data, right-aligned
//  MEM_ExcValid   in   1   MEM instruction carries an exception; access is suppressed
//  MEM_Flush      in   1   MEM stage flushed this cycle
//  WB_Wr          in   1   MEM/WB register captures this cycle
//  bus_req        out  1   request valid
//  bus_wr         out  1   request is a write
//  bus_size       out  2   = latched MEM_Size
//  bus_addr       out  32  = latched MEM_Addr
//  bus_wstrb      out  4   byte enables
//  bus_wdata      out  32  replicated store data
//  bus_addr_ok    in   1   request accepted
//  bus_data_ok    in   1   response valid (read data or write ack)
//  bus_rdata      in   32  read data
//  MEM_DMOut      out  32  load word for WB
//  MEM_Stall      out  1   freeze IF..MEM and hold MEM/WB
//  MEM_BusErr     out  1   one-cycle pulse on watchdog timeout
// BEHAVIOUR
//  Reset: state IDLE; bus_req, bus_wr, MEM_Stall, MEM_BusErr = 0; MEM_DMOut, latches, counter = 0.
//  start = MEM_Req & ~MEM_ExcValid & ~MEM_Flush.
//  IDLE: on start, latch addr/size/wr/wstrb/wdata and go to REQ; MEM_Stall = start (combinational).
//  REQ: bus_req = 1 with stable latched fields until bus_addr_ok. On addr_ok go to WAIT, or to DONE if data_ok is in the same cycle.
//  WAIT: counter increments each cycle. On bus_data_ok, load: MEM_DMOut <= bus_rdata, go to DONE.
//  WAIT with TIMEOUT_CYCLES != 0 and counter == TIMEOUT_CYCLES: MEM_BusErr = 1 for one cycle, MEM_DMOut <= 0, go to DONE.
//  DONE: MEM_Stall = 0; MEM_DMOut held. When WB_Wr = 1, go to IDLE. Store leaves MEM_DMOut unchanged.
//  MEM_Stall = start in IDLE, 1 in REQ/WAIT, 0 in DONE.
//  Latency: minimum 2 stall cycles (IDLE->REQ->DONE with addr_ok & data_ok in same cycle).
//  wstrb: byte -> 4'b0001 << addr[1:0]; half -> addr[1] ? 4'b1100 : 4'b0011; word -> 4'b1111. Loads: wstrb = 0.
//  wdata: byte -> {4{wd[7:0]}}; half -> {2{wd[15:0]}}; word -> wd.
//  Flush in REQ or WAIT: set cancel flag. The bus transaction still completes (req is never retracted).
//  On completion with cancel set: go to IDLE, not DONE; MEM_DMOut is not updated; cancel clears. MEM_Stall stays 1 until completion.
//  Flush in DONE: go to IDLE.
//  Flush in IDLE: no request.
//  MEM_ExcValid = 1: never starts an access.
//  One outstanding transaction; a new start is only accepted in IDLE.
//  Counter resets on entry to WAIT.
//  rst mid-transaction: immediate return to IDLE, all outputs to reset values. Bus-side completion after reset is ignored.
// TESTING
//  1 LW addr 0x1000, addr_ok at cycle 1, data_ok at cycle 3 with 0xCAFEF00D -> MEM_Stall high 4 cycles, MEM_DMOut = 0xCAFEF00D held until WB_Wr.
//  2 SB addr 0x2003, wd 0x000000A5 -> bus_wr = 1, wstrb 4'b1000, wdata 0xA5A5A5A5; SH addr 0x2002 -> wstrb 4'b1100.
//  3 LW with MEM_Flush pulsed in WAIT, data_ok 0x12345678 -> FSM returns to IDLE, MEM_DMOut keeps its old value, no DONE state.
//  4 LW complete, WB_Wr low 5 cycles -> MEM_Stall = 0, MEM_DMOut stable, no new bus_req until WB_Wr = 1.
//  5 TIMEOUT_CYCLES = 4, data_ok never asserted -> MEM_BusErr pulses once after 4 WAIT cycles, MEM_DMOut = 0, FSM in DONE.
//  6 rst asserted in REQ with bus_req = 1 -> bus_req = 0 and MEM_Stall = 0 in the same cycle (async); MEM_ExcValid = 1 with MEM_Req = 1 -> no bus_req.

Source files
------------

// File: rtl/mem_uncache_ctrl.sv
// mem_uncache_ctrl: MEM-stage load/store controller for a single-outstanding sram-like bus
//   clk, rst                      clock, asynchronous active-high reset
//   MEM_Req/IsStore/Size/Addr/WData  access request from the MEM instruction
//   MEM_ExcValid, MEM_Flush       suppress / cancel the access
//   WB_Wr                         MEM/WB register captures the held result
//   bus_*                         sram-like request/response channel
//   MEM_DMOut                     raw load word, MEM_Stall pipeline freeze, MEM_BusErr watchdog pulse
module mem_uncache_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MEM_Req,
    input  logic        MEM_IsStore,
    input  logic [1:0]  MEM_Size,
    input  logic [31:0] MEM_Addr,
    input  logic [31:0] MEM_WData,
    input  logic        MEM_ExcValid,
    input  logic        MEM_Flush,
    input  logic        WB_Wr,
    output logic        bus_req,
    output logic        bus_wr,
    output logic [1:0]  bus_size,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_wstrb,
    output logic [31:0] bus_wdata,
    input  logic        bus_addr_ok,
    input  logic        bus_data_ok,
    input  logic [31:0] bus_rdata,
    output logic [31:0] MEM_DMOut,
    output logic        MEM_Stall,
    output logic        MEM_BusErr
);
    localparam int CW = TIMEOUT_CYCLES > 0 ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    state_t        state, state_nx;
    logic [CW-1:0] cnt;
    logic          wr_q, cancel, start, timeout, finish, kill;
    logic [3:0]    wstrb_nx;
    logic [31:0]   wdata_nx;

    assign start   = MEM_Req & ~MEM_ExcValid & ~MEM_Flush;
    // data_ok wins over the watchdog when both land in the same cycle
    assign timeout = state == WAIT && TIMEOUT_CYCLES != 0 && cnt == CW'(TIMEOUT_CYCLES) && !bus_data_ok;
    assign finish  = (state == REQ && bus_addr_ok && bus_data_ok) || (state == WAIT && (bus_data_ok || timeout));
    // a flush arriving in the completion cycle itself cancels just like an earlier one
    assign kill    = cancel | MEM_Flush;

    assign wstrb_nx = !MEM_IsStore      ? 4'b0000 :
                      MEM_Size == 2'd0  ? 4'b0001 << MEM_Addr[1:0] :
                      MEM_Size == 2'd1  ? (MEM_Addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    assign wdata_nx = MEM_Size == 2'd0 ? {4{MEM_WData[7:0]}} :
                      MEM_Size == 2'd1 ? {2{MEM_WData[15:0]}} : MEM_WData;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = start ? REQ : IDLE;
            REQ:     state_nx = !bus_addr_ok ? REQ : !bus_data_ok ? WAIT : kill ? IDLE : DONE;
            WAIT:    state_nx = !finish ? WAIT : kill ? IDLE : DONE;
            default: state_nx = (WB_Wr || MEM_Flush) ? IDLE : DONE;
        endcase
    end

    always_comb begin
        bus_req    = state == REQ;
        bus_wr     = state == REQ && wr_q;
        MEM_Stall  = state == IDLE ? start : state != DONE;
        MEM_BusErr = timeout;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q      <= 1'b0;
            bus_size  <= 2'd0;
            bus_addr  <= 32'd0;
            bus_wstrb <= 4'd0;
            bus_wdata <= 32'd0;
            cnt       <= '0;
            cancel    <= 1'b0;
            MEM_DMOut <= 32'd0;
        end else begin
            if (state == IDLE && start) begin
                wr_q      <= MEM_IsStore;
                bus_size  <= MEM_Size;
                bus_addr  <= MEM_Addr;
                bus_wstrb <= wstrb_nx;
                bus_wdata <= wdata_nx;
            end
            cnt    <= state == WAIT ? cnt + CW'(1) : '0;
            cancel <= (state == REQ || state == WAIT) && !finish && kill;
            if (finish && !kill)
                MEM_DMOut <= timeout ? 32'd0 : wr_q ? MEM_DMOut : bus_rdata;
        end
    end
endmodule
